// File: rtl/apb_master.sv
// apb_master: APB4 requester that runs valid/ready commands as SETUP/ACCESS transfers.
// Wait states are honoured; an optional timeout abandons a stalled ACCESS.
module apb_master #(
   parameter int AWIDTH  = 4,
   parameter int DWIDTH  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                pclk,
   input  logic                presetn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [AWIDTH-1:0]   cmd_addr,
   input  logic [DWIDTH-1:0]   cmd_wdata,
   input  logic [DWIDTH/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DWIDTH-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [AWIDTH-1:0]   paddr,
   output logic [DWIDTH-1:0]   pwdata,
   output logic [DWIDTH/8-1:0] pstrb,
   input  logic                pready,
   input  logic [DWIDTH-1:0]   prdata,
   input  logic                pslverr
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   assign cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state       <= IDLE;
         cnt         <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= '0;
      end else begin
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         case (state)
            IDLE: if (cmd_valid && cmd_ready) begin
               state   <= SETUP;
               cnt     <= '0;
               psel    <= 1'b1;
               penable <= 1'b0;
               paddr   <= cmd_addr;
               pwrite  <= cmd_write;
               pwdata  <= cmd_write ? cmd_wdata : '0;
               pstrb   <= cmd_write ? cmd_strb : '0;
            end
            SETUP: begin
               state   <= ACCESS;
               penable <= 1'b1;
            end
            ACCESS: if (pready) begin
               state       <= IDLE;
               psel        <= 1'b0;
               penable     <= 1'b0;
               rsp_valid   <= 1'b1;
               rsp_rdata   <= pwrite ? '0 : prdata;
               rsp_err     <= pslverr;
               rsp_timeout <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
               // abort on the TIMEOUT-th consecutive stalled ACCESS cycle
               if (TIMEOUT != 0 && cnt == LAST) begin
                  state       <= IDLE;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
